// File: rtl/vm80a_sysctl.sv
// Bus responder for the vm80a pin bus: latches SYNC status, issues one-clock system
// requests, stretches READY until acknowledge, and answers INTA with an RST opcode.
module vm80a_sysctl #(
  parameter logic [7:0]  RST_VEC   = 8'hE7,
  parameter logic [16:0] MEM_LIMIT = 17'h04000,
  parameter int unsigned MIN_WAIT  = 0
) (
  input  logic        pin_clk,
  input  logic        pin_reset_n,
  input  logic [15:0] pin_a,
  input  logic [7:0]  pin_din,
  output logic [7:0]  pin_dout,
  output logic        pin_doe,
  input  logic        pin_sync,
  input  logic        pin_dbin,
  input  logic        pin_wr_n,
  output logic        pin_ready,
  output logic [15:0] sys_addr,
  output logic [7:0]  sys_wdata,
  input  logic [7:0]  sys_rdata,
  output logic        sys_memrd,
  output logic        sys_memwr,
  output logic        sys_iord,
  output logic        sys_iowr,
  input  logic        sys_ack,
  output logic [7:0]  sys_status,
  output logic        sys_fault
);

  localparam int unsigned WAIT_W = 4;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t              state, state_next;
  logic                dbin_q, wr_n_q, ack_seen, is_read;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                rd_rise, wr_fall, mem_fault, start;
  logic                memrd_c, memwr_c, iord_c, iowr_c, inta_c, fault_c;

  assign rd_rise   = pin_dbin & ~dbin_q;
  assign wr_fall   = ~pin_wr_n & wr_n_q;
  assign mem_fault = ({1'b0, pin_a} >= MEM_LIMIT);
  assign pin_doe   = pin_dbin & (state != IDLE);

  // Next state and one-clock request decode; write edge has priority over read edge
  always_comb begin
    state_next = state;
    start      = 1'b0;
    memrd_c    = 1'b0;
    memwr_c    = 1'b0;
    iord_c     = 1'b0;
    iowr_c     = 1'b0;
    inta_c     = 1'b0;
    fault_c    = 1'b0;
    if (pin_sync) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (wr_fall || rd_rise) begin
            start      = 1'b1;
            state_next = DONE;
            if (wr_fall) begin
              if (!sys_status[3]) begin
                if (sys_status[4])  iowr_c  = 1'b1;
                else if (mem_fault) fault_c = 1'b1;
                else                memwr_c = 1'b1;
              end
            end else if (sys_status[0]) begin
              inta_c = 1'b1;
            end else if (!sys_status[3]) begin
              if (sys_status[7]) begin
                if (mem_fault) fault_c = 1'b1;
                else           memrd_c = 1'b1;
              end else if (sys_status[6]) begin
                iord_c = 1'b1;
              end
            end
            if (memrd_c || memwr_c || iord_c || iowr_c) state_next = ACCESS;
          end
        end
        ACCESS: if ((sys_ack || ack_seen) && wait_cnt == '0) state_next = DONE;
        DONE:   if (!pin_dbin && pin_wr_n) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge pin_clk or negedge pin_reset_n) begin
    if (!pin_reset_n) state <= IDLE;
    else              state <= state_next;
  end

  // Registered pin/system outputs and access bookkeeping
  always_ff @(posedge pin_clk or negedge pin_reset_n) begin
    if (!pin_reset_n) begin
      dbin_q     <= 1'b0;
      wr_n_q     <= 1'b1;
      sys_status <= 8'h00;
      sys_memrd  <= 1'b0;
      sys_memwr  <= 1'b0;
      sys_iord   <= 1'b0;
      sys_iowr   <= 1'b0;
      sys_fault  <= 1'b0;
      pin_ready  <= 1'b1;
      pin_dout   <= 8'hFF;
      sys_addr   <= 16'h0000;
      sys_wdata  <= 8'h00;
      is_read    <= 1'b0;
      ack_seen   <= 1'b0;
      wait_cnt   <= '0;
    end else begin
      dbin_q    <= pin_dbin;
      wr_n_q    <= pin_wr_n;
      if (pin_sync) sys_status <= pin_din;
      sys_memrd <= memrd_c;
      sys_memwr <= memwr_c;
      sys_iord  <= iord_c;
      sys_iowr  <= iowr_c;
      sys_fault <= fault_c;
      pin_ready <= (state_next != ACCESS);
      if (start) begin
        sys_addr <= (iord_c || iowr_c) ? {pin_a[7:0], pin_a[7:0]} : pin_a;
        is_read  <= ~wr_fall;
        wait_cnt <= WAIT_W'(MIN_WAIT);
        ack_seen <= 1'b0;
        if (wr_fall) sys_wdata <= pin_din;
      end else if (state == ACCESS) begin
        if (wait_cnt != '0) wait_cnt <= wait_cnt - WAIT_W'(1);
        if (sys_ack)        ack_seen <= 1'b1;
      end
      // Read data is latched on the acknowledge itself and held until the next read
      if (inta_c)                                     pin_dout <= RST_VEC;
      else if (fault_c)                               pin_dout <= 8'hFF;
      else if (state == ACCESS && sys_ack && is_read) pin_dout <= sys_rdata;
    end
  end

endmodule

// File: tb/tb_vm80a_sysctl.sv
// Directed bench for vm80a_sysctl: default instance plus a MIN_WAIT=3 instance on shared pins.
module tb_vm80a_sysctl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] a;
  logic [7:0]  din, rdata;
  logic        sync, dbin, wr_n, ack, ack2;

  logic [7:0]  dout, wdata, status;
  logic        doe, ready, memrd, memwr, iord, iowr, fault;
  logic [15:0] addr;

  logic [7:0]  dout2, wdata2, status2;
  logic        doe2, ready2, memrd2, memwr2, iord2, iowr2, fault2;
  logic [15:0] addr2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vm80a_sysctl u1 (
    .pin_clk(clk), .pin_reset_n(rst_n), .pin_a(a), .pin_din(din), .pin_dout(dout),
    .pin_doe(doe), .pin_sync(sync), .pin_dbin(dbin), .pin_wr_n(wr_n), .pin_ready(ready),
    .sys_addr(addr), .sys_wdata(wdata), .sys_rdata(rdata), .sys_memrd(memrd),
    .sys_memwr(memwr), .sys_iord(iord), .sys_iowr(iowr), .sys_ack(ack),
    .sys_status(status), .sys_fault(fault)
  );

  vm80a_sysctl #(.MIN_WAIT(3)) u2 (
    .pin_clk(clk), .pin_reset_n(rst_n), .pin_a(a), .pin_din(din), .pin_dout(dout2),
    .pin_doe(doe2), .pin_sync(sync), .pin_dbin(dbin), .pin_wr_n(wr_n), .pin_ready(ready2),
    .sys_addr(addr2), .sys_wdata(wdata2), .sys_rdata(rdata), .sys_memrd(memrd2),
    .sys_memwr(memwr2), .sys_iord(iord2), .sys_iowr(iowr2), .sys_ack(ack2),
    .sys_status(status2), .sys_fault(fault2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; a = '0; din = '0; rdata = '0;
    sync = 1'b0; dbin = 1'b0; wr_n = 1'b1; ack = 1'b0; ack2 = 1'b0;
    #12;
    chk("rst_dout",   32'(dout), 32'hFF);
    chk("rst_doe",    32'(doe), 32'h0);
    chk("rst_ready",  32'(ready), 32'h1);
    chk("rst_strobe", 32'({memrd, memwr, iord, iowr, fault}), 32'h0);
    chk("rst_addr",   32'(addr), 32'h0);
    chk("rst_wdata",  32'(wdata), 32'h0);
    chk("rst_status", 32'(status), 32'h0);
    step();
    rst_n = 1'b1;
    step();

    // Memory read, ack three clocks after the strobe
    sync = 1'b1; din = 8'hA2; step();
    chk("rd_status", 32'(status), 32'hA2);
    sync = 1'b0; din = 8'h00; dbin = 1'b1; a = 16'h0123; step();
    chk("rd_memrd1",  32'(memrd), 32'h1);
    chk("rd_ready1",  32'(ready), 32'h0);
    chk("rd_addr",    32'(addr), 32'h0123);
    chk("rd_doe",     32'(doe), 32'h1);
    chk("rd_others",  32'({memwr, iord, iowr, fault}), 32'h0);
    step();
    chk("rd_memrd2",  32'(memrd), 32'h0);
    chk("rd_ready2",  32'(ready), 32'h0);
    step();
    chk("rd_ready3",  32'(ready), 32'h0);
    ack = 1'b1; rdata = 8'h3E; step();
    chk("rd_ready4",  32'(ready), 32'h1);
    chk("rd_dout",    32'(dout), 32'h3E);
    ack = 1'b0; rdata = 8'h00; dbin = 1'b0; step();
    chk("rd_doe_off", 32'(doe), 32'h0);
    chk("rd_dout_hold", 32'(dout), 32'h3E);

    // Interrupt acknowledge
    sync = 1'b1; din = 8'h23; step();
    sync = 1'b0; din = 8'h00; dbin = 1'b1; step();
    chk("inta_dout",   32'(dout), 32'hE7);
    chk("inta_ready",  32'(ready), 32'h1);
    chk("inta_strobe", 32'({memrd, memwr, iord, iowr, fault}), 32'h0);
    chk("inta_doe",    32'(doe), 32'h1);
    step();
    chk("inta_ready2", 32'(ready), 32'h1);
    dbin = 1'b0; step();

    // IO write
    sync = 1'b1; din = 8'h10; step();
    sync = 1'b0; wr_n = 1'b0; a = 16'h4242; din = 8'h55; step();
    chk("out_iowr",  32'(iowr), 32'h1);
    chk("out_memwr", 32'(memwr), 32'h0);
    chk("out_addr",  32'(addr), 32'h4242);
    chk("out_wdata", 32'(wdata), 32'h55);
    chk("out_ready", 32'(ready), 32'h0);
    chk("out_doe",   32'(doe), 32'h0);
    ack = 1'b1; step();
    chk("out_ready_ack", 32'(ready), 32'h1);
    chk("out_iowr_off",  32'(iowr), 32'h0);
    ack = 1'b0; wr_n = 1'b1; step();

    // Memory write at the fault limit
    sync = 1'b1; din = 8'h00; step();
    sync = 1'b0; wr_n = 1'b0; a = 16'h4000; din = 8'hAA; step();
    chk("flt_pulse", 32'(fault), 32'h1);
    chk("flt_memwr", 32'(memwr), 32'h0);
    chk("flt_ready", 32'(ready), 32'h1);
    chk("flt_dout",  32'(dout), 32'hFF);
    step();
    chk("flt_pulse_end", 32'(fault), 32'h0);
    chk("flt_ready2",    32'(ready), 32'h1);
    wr_n = 1'b1; step();

    // Memory write one below the limit
    sync = 1'b1; din = 8'h00; step();
    sync = 1'b0; wr_n = 1'b0; a = 16'h3FFF; din = 8'h77; step();
    chk("lim_memwr", 32'(memwr), 32'h1);
    chk("lim_fault", 32'(fault), 32'h0);
    chk("lim_wdata", 32'(wdata), 32'h77);
    ack = 1'b1; step();
    chk("lim_ready", 32'(ready), 32'h1);
    ack = 1'b0; wr_n = 1'b1; step();

    // IO read duplicates the low address byte
    sync = 1'b1; din = 8'h42; step();
    sync = 1'b0; din = 8'h00; dbin = 1'b1; a = 16'h9C17; step();
    chk("inp_iord", 32'(iord), 32'h1);
    chk("inp_addr", 32'(addr), 32'h1717);
    ack = 1'b1; rdata = 8'hC4; step();
    chk("inp_dout", 32'(dout), 32'hC4);
    ack = 1'b0; dbin = 1'b0; step();

    // MIN_WAIT=3 instance, ack in the same clock as the strobe
    sync = 1'b1; din = 8'h82; step();
    sync = 1'b0; din = 8'h00; dbin = 1'b1; a = 16'h0010; step();
    chk("mw_memrd",  32'(memrd2), 32'h1);
    chk("mw_ready1", 32'(ready2), 32'h0);
    ack2 = 1'b1; rdata = 8'h5A; step();
    chk("mw_ready2", 32'(ready2), 32'h0);
    chk("mw_dout",   32'(dout2), 32'h5A);
    ack2 = 1'b0; rdata = 8'h00; step();
    chk("mw_ready3", 32'(ready2), 32'h0);
    step();
    chk("mw_ready4", 32'(ready2), 32'h0);
    step();
    chk("mw_ready5", 32'(ready2), 32'h1);
    dbin = 1'b0; step();

    // Reset in the middle of an access
    sync = 1'b1; din = 8'hA2; step();
    sync = 1'b0; din = 8'h00; dbin = 1'b1; a = 16'h0200; step();
    chk("mr_ready_pre", 32'(ready), 32'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_ready",  32'(ready), 32'h1);
    chk("mr_doe",    32'(doe), 32'h0);
    chk("mr_strobe", 32'({memrd, memwr, iord, iowr, fault}), 32'h0);
    step();
    rst_n = 1'b1;
    step();
    chk("mr_post1",  32'({memrd, memwr, iord, iowr, fault}), 32'h0);
    chk("mr_ready1", 32'(ready), 32'h1);
    step();
    chk("mr_post2",  32'({memrd, memwr, iord, iowr, fault}), 32'h0);
    dbin = 1'b0; step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
